// File: rtl/nz_index_scanner.sv
// Turns a nonzero-activation bitmask chunk into a stream of global indices,
// lowest set bit first, one per cycle, with ready/valid on both sides.
module nz_index_scanner #(
  parameter int unsigned BIT_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mask_valid,
  output logic                  mask_ready,
  input  logic [BIT_WIDTH-1:0]  mask_data,
  input  logic [ADDR_WIDTH-1:0] mask_base,
  output logic                  idx_valid,
  input  logic                  idx_ready,
  output logic [ADDR_WIDTH-1:0] idx_addr,
  output logic                  idx_last,
  output logic                  done
);

  localparam int unsigned POS_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [BIT_WIDTH-1:0]  work_q, work_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  last_d, valid_d, ready_d, done_d;

  // Priority detector: index of the lowest set bit (0 for an empty mask).
  function automatic logic [POS_W-1:0] lowest_pos(input logic [BIT_WIDTH-1:0] m);
    lowest_pos = '0;
    for (int i = BIT_WIDTH - 1; i >= 0; i--) begin
      if (m[i]) lowest_pos = POS_W'(i);
    end
  endfunction

  function automatic logic single_bit(input logic [BIT_WIDTH-1:0] m);
    single_bit = (m != '0) && ((m & (m - BIT_WIDTH'(1))) == '0);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      work_q     <= '0;
      base_q     <= '0;
      mask_ready <= 1'b1;
      idx_valid  <= 1'b0;
      idx_addr   <= '0;
      idx_last   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      base_q     <= base_d;
      mask_ready <= ready_d;
      idx_valid  <= valid_d;
      idx_addr   <= addr_d;
      idx_last   <= last_d;
      done       <= done_d;
    end
  end

  // Next-state logic; outputs are precomputed from the next working mask so
  // every output leaves a flop.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    base_d  = base_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mask_valid) begin
          work_d = mask_data;
          base_d = mask_base;
          if (mask_data != '0) state_d = SCAN;
          else                 done_d  = 1'b1;
        end
      end
      SCAN: begin
        if (idx_ready) begin
          work_d = work_q & (work_q - BIT_WIDTH'(1));
          if (single_bit(work_q)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == SCAN);
    ready_d = (state_d == IDLE);
    addr_d  = base_d + ADDR_WIDTH'(lowest_pos(work_d));
    last_d  = single_bit(work_d);
  end

endmodule

// File: tb/tb_nz_index_scanner.sv
// Directed and randomized checks of nz_index_scanner against a queue-based
// model that lists every set bit of a chunk as a global index.
module tb_nz_index_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mask_valid;
  logic        mask_ready;
  logic [15:0] mask_data;
  logic [9:0]  mask_base;
  logic        idx_valid;
  logic        idx_ready;
  logic [9:0]  idx_addr;
  logic        idx_last;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  nz_index_scanner #(.BIT_WIDTH(16), .ADDR_WIDTH(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mask_valid (mask_valid),
    .mask_ready (mask_ready),
    .mask_data  (mask_data),
    .mask_base  (mask_base),
    .idx_valid  (idx_valid),
    .idx_ready  (idx_ready),
    .idx_addr   (idx_addr),
    .idx_last   (idx_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one chunk from a negedge, drain it with random backpressure and
  // check each beat and the done pulse. Caller stands at a negedge.
  task automatic run_chunk(input logic [15:0] m, input logic [9:0] b,
                           input int stall_pct, input int init_stall);
    int q[$];
    int guard;
    int beat;
    for (int i = 0; i < 16; i++)
      if (m[i]) q.push_back((int'(b) + i) % 1024);
    chk("ready_before_accept", 32'(mask_ready), 32'd1);
    mask_valid = 1'b1;
    mask_data  = m;
    mask_base  = b;
    idx_ready  = 1'b0;
    @(negedge clk);
    mask_valid = 1'b0;
    if (q.size() == 0) begin
      chk("empty_valid", 32'(idx_valid), 32'd0);
      chk("empty_done", 32'(done), 32'd1);
      chk("empty_ready", 32'(mask_ready), 32'd1);
    end else begin
      guard = 0;
      beat  = 0;
      while (q.size() > 0 && guard < 400) begin
        chk("beat_valid", 32'(idx_valid), 32'd1);
        chk("beat_addr", 32'(idx_addr), 32'(q[0]));
        chk("beat_last", 32'(idx_last), (q.size() == 1) ? 32'd1 : 32'd0);
        chk("beat_busy", 32'(mask_ready), 32'd0);
        chk("beat_nodone", 32'(done), 32'd0);
        idx_ready = (beat >= init_stall) && ($urandom_range(99) >= stall_pct);
        beat++;
        @(negedge clk);
        if (idx_ready) void'(q.pop_front());
        guard++;
      end
      if (q.size() != 0) chk("drain_budget", 32'(q.size()), 32'd0);
      idx_ready = 1'b0;
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_valid", 32'(idx_valid), 32'd0);
      chk("done_ready", 32'(mask_ready), 32'd1);
    end
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    logic [15:0] rm;
    rst_n      = 1'b0;
    mask_valid = 1'b0;
    mask_data  = '0;
    mask_base  = '0;
    idx_ready  = 1'b0;
    #12;
    chk("rst_ready", 32'(mask_ready), 32'd1);
    chk("rst_valid", 32'(idx_valid), 32'd0);
    chk("rst_addr", 32'(idx_addr), 32'd0);
    chk("rst_last", 32'(idx_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_chunk(16'h8421, 10'd100, 0, 0);
    run_chunk(16'h0000, 10'd7, 0, 0);
    run_chunk(16'h0003, 10'd0, 0, 3);
    run_chunk(16'h0030, 10'd1020, 0, 0);

    // Full mask with a second chunk held on the input throughout the scan.
    mask_valid = 1'b1;
    mask_data  = 16'hFFFF;
    mask_base  = 10'd0;
    @(negedge clk);
    mask_data = 16'h0001;
    mask_base = 10'd50;
    for (int i = 0; i < 16; i++) begin
      chk("full_valid", 32'(idx_valid), 32'd1);
      chk("full_addr", 32'(idx_addr), 32'(i));
      chk("full_last", 32'(idx_last), (i == 15) ? 32'd1 : 32'd0);
      chk("full_busy", 32'(mask_ready), 32'd0);
      idx_ready = 1'b1;
      @(negedge clk);
    end
    idx_ready = 1'b0;
    chk("full_done", 32'(done), 32'd1);
    chk("full_ready_in_done", 32'(mask_ready), 32'd1);
    @(negedge clk);
    mask_valid = 1'b0;
    chk("held_valid", 32'(idx_valid), 32'd1);
    chk("held_addr", 32'(idx_addr), 32'd50);
    chk("held_last", 32'(idx_last), 32'd1);
    chk("held_nodone", 32'(done), 32'd0);
    idx_ready = 1'b1;
    @(negedge clk);
    idx_ready = 1'b0;
    chk("held_done", 32'(done), 32'd1);
    @(negedge clk);

    // Reset after two of four indices have been consumed.
    mask_valid = 1'b1;
    mask_data  = 16'h00F0;
    mask_base  = 10'd0;
    @(negedge clk);
    mask_valid = 1'b0;
    idx_ready  = 1'b1;
    chk("pre_rst_addr0", 32'(idx_addr), 32'd4);
    @(negedge clk);
    chk("pre_rst_addr1", 32'(idx_addr), 32'd5);
    @(negedge clk);
    chk("pre_rst_addr2", 32'(idx_addr), 32'd6);
    idx_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("midrst_valid", 32'(idx_valid), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(mask_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_valid", 32'(idx_valid), 32'd0);
    run_chunk(16'h0001, 10'd3, 0, 0);

    // Randomized chunks: dense, sparse and empty masks, random backpressure.
    for (int k = 0; k < 40; k++) begin
      rm = 16'($urandom);
      case ($urandom_range(3))
        0: rm = rm & 16'($urandom);
        1: rm = 16'h0;
        default: ;
      endcase
      run_chunk(rm, 10'($urandom), 35, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
